c_wrr_arbiter: RTL and testbench
================================

C_WRR_ARBITER -- requirements
Module: c_wrr_arbiter

Interface
REQ-001 SHALL have parameter num_ports, default 4: number of requesting ports, >=2.
REQ-002 SHALL have parameter num_priorities, default 1: number of priority levels; level 0 is highest.
REQ-003 SHALL have parameter weight_width, default 4: width of each per-port weight field.
REQ-004 SHALL have parameter hold_enable, default 1: 1 enables packet-hold locking; 0 ties the lock off.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port reset, input, 1: reset. One clock; reset is synchronous and active-low.
REQ-007 SHALL have port active, input, 1: clock-gating qualifier; state updates only when 1.
REQ-008 SHALL have port req_pr, input, num_priorities*num_ports: requests; bit p*num_ports+i is port i at level p (MSB-first [0:...] ordering).
REQ-009 SHALL have port weights, input, num_ports*weight_width: field i is the weight of port i (MSB-first); quasi-static.
REQ-010 SHALL have port hold, input, 1: current grant is not the last of its packet.
REQ-011 SHALL have port update, input, 1: the current grant is consumed this cycle.
REQ-012 SHALL have port gnt_pr, output, num_priorities*num_ports: one-hot-or-zero grant, same layout as req_pr.
REQ-013 SHALL have port gnt, output, num_ports: OR of gnt_pr across levels.
REQ-014 SHALL have port locked, output, 1: the hold lock is active.

Function
REQ-015 SHALL compute gnt_pr/gnt combinationally from req_pr and registered state; zero request-to-grant latency.
REQ-016 SHALL select the highest level p with any request; only level-p requests compete.
REQ-017 SHALL grant, within level p, the first requesting port at or after pointer ptr, searching cyclically (ptr, ptr+1, ..., num_ports-1, 0, ...).
REQ-018 SHALL override arbitration while locked=1 and port lock_port has a request at any level: grant lock_port at its highest requested level.
REQ-019 SHALL use normal arbitration while locked=1 and lock_port has no request; locked stays 1.
REQ-020 SHALL assert gnt_pr=0 and gnt=0 when req_pr=0.
REQ-021 SHALL treat an update event as reset=1 & active & update & |gnt; no state changes otherwise.
REQ-022 SHALL, on an update event with hold=1 and hold_enable=1, set locked=1 and lock_port=w (the granted port), leaving ptr and cnt unchanged.
REQ-023 SHALL, on an update event with hold=0, or with hold_enable=0, clear locked and apply the weight rule to the granted port w.
REQ-024 SHALL apply the weight rule as follows: c = ((w==ptr) ? cnt : 0) + 1; effective weight W = max(weights[w], 1).
REQ-025 SHALL, when c >= W, set ptr = (w+1) mod num_ports and cnt = 0; else set ptr = w and cnt = c.
REQ-026 SHALL size cnt at weight_width bits with no overflow, since c <= W <= 2^weight_width-1.
REQ-027 SHALL wrap ptr from num_ports-1 to 0.
REQ-028 SHALL let a weight change take effect at the next update event, without resetting cnt.
REQ-029 SHALL drive locked as a direct register output; it is 0 whenever hold_enable=0.

Reset
REQ-030 SHALL, on a rising clk edge with reset=0, set ptr=0, cnt=0, locked=0 and lock_port=0, overriding active and update.
REQ-031 SHALL, while reset=0, still drive combinational grants from the reset state (ptr=0, unlocked).
REQ-032 SHALL abort any in-progress lock or weight count when reset is asserted mid-operation.

Verification
REQ-033 SHALL verify: num_ports=4, weights=1,1,1,1, all ports requesting at level 0, update every cycle -> gnt = 1000, 0100, 0010, 0001, 1000, ...
REQ-034 SHALL verify: weights=3,1,2,1, all ports requesting, update every cycle -> grant sequence per port index 0,0,0,1,2,2,3,0,...
REQ-035 SHALL verify: num_priorities=2, req_pr level1=1111 and level0=0010 -> gnt_pr level0=0010 only; then level0 cleared -> level1 round-robin resumes from the updated ptr.
REQ-036 SHALL verify: grant to port 2 with hold=1 for 3 updates while ports 0-3 all request -> gnt=0010 throughout and locked=1; update with hold=0 -> locked=0 and ptr advances per the weight rule.
REQ-037 SHALL verify: active=0 with update=1 for 5 cycles -> ptr, cnt and locked unchanged and gnt constant.
REQ-038 SHALL verify: reset=0 pulsed mid-lock with cnt=2 -> next cycle locked=0, and with all ports requesting gnt=1000.

Source files
------------

// File: rtl/c_wrr_arbiter.sv
// Weighted round-robin arbiter with strict priority levels and packet-hold locking.
// Grants are combinational from requests and registered pointer/count/lock state.
module c_wrr_arbiter #(
  parameter int unsigned num_ports      = 4,
  parameter int unsigned num_priorities = 1,
  parameter int unsigned weight_width   = 4,
  parameter int unsigned hold_enable    = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  active,
  input  logic [0:num_priorities*num_ports-1]   req_pr,
  input  logic [0:num_ports*weight_width-1]     weights,
  input  logic                                  hold,
  input  logic                                  update,
  output logic [0:num_priorities*num_ports-1]   gnt_pr,
  output logic [0:num_ports-1]                  gnt,
  output logic                                  locked
);

  localparam int unsigned ptr_width = (num_ports > 1) ? $clog2(num_ports) : 1;
  localparam logic        hold_en   = 1'(hold_enable != 0);

  logic [ptr_width-1:0]    ptr;
  logic [ptr_width-1:0]    lock_port;
  logic [ptr_width-1:0]    win;
  logic [weight_width-1:0] cnt;
  logic [weight_width-1:0] wt_sel;
  logic [weight_width-1:0] eff_wt;
  logic [weight_width-1:0] c_next;
  logic                    any_gnt;

  // Grant selection: lock override first, else highest level with a cyclic search from ptr.
  always_comb begin
    logic found;
    gnt_pr = '0;
    win    = '0;
    found  = 1'b0;
    if (locked) begin
      for (int p = 0; p < int'(num_priorities); p++) begin
        for (int i = 0; i < int'(num_ports); i++) begin
          if (!found && i == int'(lock_port) && req_pr[p*num_ports + i]) begin
            found                  = 1'b1;
            gnt_pr[p*num_ports + i] = 1'b1;
            win                    = ptr_width'(i);
          end
        end
      end
    end
    for (int p = 0; p < int'(num_priorities); p++) begin
      if (!found && req_pr[p*num_ports +: num_ports] != '0) begin
        // First pass covers ptr..end, second pass wraps around to the ports below ptr.
        for (int i = 0; i < int'(num_ports); i++) begin
          if (!found && i >= int'(ptr) && req_pr[p*num_ports + i]) begin
            found                  = 1'b1;
            gnt_pr[p*num_ports + i] = 1'b1;
            win                    = ptr_width'(i);
          end
        end
        for (int i = 0; i < int'(num_ports); i++) begin
          if (!found && req_pr[p*num_ports + i]) begin
            found                  = 1'b1;
            gnt_pr[p*num_ports + i] = 1'b1;
            win                    = ptr_width'(i);
          end
        end
      end
    end
  end

  // Collapse levels into a per-port grant.
  always_comb begin
    gnt = '0;
    for (int p = 0; p < int'(num_priorities); p++) begin
      gnt = gnt | gnt_pr[p*num_ports +: num_ports];
    end
  end

  assign any_gnt = |gnt;

  // Weight rule inputs for the granted port; a zero weight behaves as one.
  always_comb begin
    wt_sel = '0;
    for (int i = 0; i < int'(num_ports); i++) begin
      if (i == int'(win)) begin
        wt_sel = weights[i*weight_width +: weight_width];
      end
    end
    eff_wt = (wt_sel == '0) ? weight_width'(1) : wt_sel;
    c_next = ((win == ptr) ? cnt : '0) + weight_width'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr       <= '0;
      cnt       <= '0;
      locked    <= 1'b0;
      lock_port <= '0;
    end else if (active && update && any_gnt) begin
      if (hold && hold_en) begin
        locked    <= 1'b1;
        lock_port <= win;
      end else begin
        locked <= 1'b0;
        if (c_next >= eff_wt) begin
          ptr <= (win == ptr_width'(num_ports - 1)) ? '0 : win + ptr_width'(1);
          cnt <= '0;
        end else begin
          ptr <= win;
          cnt <= c_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_c_wrr_arbiter.sv
// Bench for c_wrr_arbiter: directed scenarios plus random traffic, expectations
// queued by a reference model and checked by a separate negedge monitor.
module tb_c_wrr_arbiter;

  localparam int NP  = 4;
  localparam int NPR = 2;
  localparam int WW  = 4;
  localparam int GW  = NP * NPR;

  logic            clk = 1'b0;
  logic            reset;
  logic            active;
  logic            hold;
  logic            update;
  logic            locked;
  logic [0:GW-1]   req_pr;
  logic [0:GW-1]   gnt_pr;
  logic [0:NP*WW-1] weights;
  logic [0:NP-1]   gnt;

  c_wrr_arbiter #(
    .num_ports(NP), .num_priorities(NPR), .weight_width(WW), .hold_enable(1)
  ) dut (
    .clk(clk), .reset(reset), .active(active), .req_pr(req_pr), .weights(weights),
    .hold(hold), .update(update), .gnt_pr(gnt_pr), .gnt(gnt), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:GW-1] gnt_pr;
    logic [0:NP-1] gnt;
    logic          locked;
    int            step_no;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_steps  = 0;

  // Reference model state, kept as plain integers.
  int   m_ptr = 0;
  int   m_cnt = 0;
  int   m_lock_port = 0;
  bit   m_locked = 1'b0;
  int   wt[NP];

  function automatic logic [0:GW-1] model_grant(input logic [0:GW-1] r);
    logic [0:GW-1] g;
    g = '0;
    if (m_locked) begin
      for (int p = 0; p < NPR; p++) begin
        if (r[p*NP + m_lock_port]) begin
          g[p*NP + m_lock_port] = 1'b1;
          return g;
        end
      end
    end
    for (int p = 0; p < NPR; p++) begin
      if (r[p*NP +: NP] == '0) continue;
      for (int k = 0; k < NP; k++) begin
        int i;
        i = (m_ptr + k) % NP;
        if (r[p*NP + i]) begin
          g[p*NP + i] = 1'b1;
          return g;
        end
      end
    end
    return g;
  endfunction

  function automatic void model_update(input logic [0:GW-1] g, input logic h, u, a, rs);
    int w;
    int c;
    int wmax;
    w = -1;
    for (int p = 0; p < NPR; p++)
      for (int i = 0; i < NP; i++)
        if (g[p*NP + i]) w = i;
    if (!rs) begin
      m_ptr = 0; m_cnt = 0; m_locked = 1'b0; m_lock_port = 0;
    end else if (a && u && w >= 0) begin
      if (h) begin
        m_locked    = 1'b1;
        m_lock_port = w;
      end else begin
        m_locked = 1'b0;
        c    = ((w == m_ptr) ? m_cnt : 0) + 1;
        wmax = (wt[w] < 1) ? 1 : wt[w];
        if (c >= wmax) begin
          m_ptr = (w + 1) % NP;
          m_cnt = 0;
        end else begin
          m_ptr = w;
          m_cnt = c;
        end
      end
    end
  endfunction

  task automatic set_weights();
    for (int i = 0; i < NP; i++) weights[i*WW +: WW] = WW'(wt[i]);
  endtask

  // Drive one cycle of inputs, queue the expected response, then advance the model.
  task automatic step(input logic [0:GW-1] r, input logic h, u, a, rs);
    exp_t e;
    req_pr = r; hold = h; update = u; active = a; reset = rs;
    e.gnt_pr = model_grant(r);
    e.gnt    = '0;
    for (int p = 0; p < NPR; p++) e.gnt = e.gnt | e.gnt_pr[p*NP +: NP];
    e.locked  = m_locked;
    e.step_no = n_steps;
    exp_q.push_back(e);
    model_update(e.gnt_pr, h, u, a, rs);
    n_steps++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (gnt_pr !== e.gnt_pr) begin
        n_fails++;
        $display("FAIL gnt_pr step %0d: got %b exp %b", e.step_no, gnt_pr, e.gnt_pr);
      end
      n_checks++;
      if (gnt !== e.gnt) begin
        n_fails++;
        $display("FAIL gnt step %0d: got %b exp %b", e.step_no, gnt, e.gnt);
      end
      n_checks++;
      if (locked !== e.locked) begin
        n_fails++;
        $display("FAIL locked step %0d: got %b exp %b", e.step_no, locked, e.locked);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:GW-1] r;
    reset = 1'b0; active = 1'b1; hold = 1'b0; update = 1'b0; req_pr = '0;
    wt = '{1, 1, 1, 1};
    set_weights();
    @(posedge clk);
    #1;

    // Grants are live while reset is held low.
    repeat (3) step(8'b1111_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'b0000_0000, 1'b0, 1'b1, 1'b1, 1'b1);

    // Equal weights: plain rotation.
    repeat (8) step(8'b1111_0000, 1'b0, 1'b1, 1'b1, 1'b1);

    // Weights 3,1,2,1 from a fresh pointer.
    wt = '{3, 1, 2, 1};
    set_weights();
    step(8'b1111_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) step(8'b1111_0000, 1'b0, 1'b1, 1'b1, 1'b1);

    // Level 0 dominates level 1, then level 1 resumes.
    repeat (3) step(8'b0010_1111, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (5) step(8'b0000_1111, 1'b0, 1'b1, 1'b1, 1'b1);

    // Packet hold on port 2 while everyone requests.
    step(8'b0010_0000, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) step(8'b1111_0000, 1'b1, 1'b1, 1'b1, 1'b1);
    step(8'b1111_0000, 1'b0, 1'b1, 1'b1, 1'b1);
    step(8'b1111_0000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Gated clock: nothing moves.
    repeat (5) step(8'b1111_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    step(8'b1111_0000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset mid-lock with a partial weight count on port 0.
    step(8'b1111_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(8'b1111_0000, 1'b0, 1'b1, 1'b1, 1'b1);
    step(8'b1111_0000, 1'b1, 1'b1, 1'b1, 1'b1);
    step(8'b1111_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) step(8'b1111_0000, 1'b0, 1'b1, 1'b1, 1'b1);

    // Random traffic with occasional weight changes and reset pulses.
    repeat (600) begin
      if ($urandom_range(0, 19) == 0) begin
        wt[$urandom_range(0, NP-1)] = int'($urandom_range(0, 15));
        set_weights();
      end
      r = GW'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & GW'($urandom);
      step(r,
           1'($urandom_range(0, 9) < 3),
           1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) < 17),
           1'($urandom_range(0, 39) != 0));
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: got %0d pending exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
